amo_bus_ctrl: RTL and testbench

//  Sequences an atomic read-modify-write (AMO) on the memory bus on behalf of the LSU when the target is uncached.

---
 rtl/amo_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_amo_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/amo_bus_ctrl.sv
// Uncached atomic read-modify-write sequencer: locked bus read, one cycle for the
// external amoalu, locked bus write of the result, then a single-cycle response.
module amo_bus_ctrl #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValidM,
  output logic               ReqReadyM,
  input  logic [PA_BITS-1:0] ReqAdrM,
  input  logic [6:0]         ReqFunct7M,
  input  logic [2:0]         ReqFunct3M,
  input  logic [XLEN-1:0]    ReqWDataM,
  output logic               RspValid,
  output logic [XLEN-1:0]    RspRData,
  output logic               RspErr,
  output logic [XLEN-1:0]    AluReadData,
  output logic [XLEN-1:0]    AluWriteData,
  output logic [6:0]         AluFunct7,
  output logic [2:0]         AluFunct3,
  input  logic [XLEN-1:0]    AluResult,
  output logic               BusReq,
  output logic               BusWrite,
  output logic               BusLock,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [1:0]         BusSize,
  output logic [XLEN-1:0]    BusWData,
  input  logic               BusAck,
  input  logic               BusErr,
  input  logic [XLEN-1:0]    BusRData,
  output logic               Busy,
  output logic [2:0]         dbg_state
);

  // Handshakes: a request transfers on a cycle where ReqValidM & ReqReadyM are both
  // high; a bus phase holds BusReq with stable BusAdr/BusSize/BusWData until a cycle
  // with BusAck or BusErr (BusErr wins), or until the wait counter expires.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [PA_BITS-1:0] adr_q;
  logic [6:0]         funct7_q;
  logic [2:0]         funct3_q;
  logic [XLEN-1:0]    rs2_q;
  logic [XLEN-1:0]    rdata_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    rsp_rdata_q;
  logic               rsp_err_q;
  logic [7:0]         to_cnt_q;

  logic               accept;
  logic               size_word, size_dword, req_bad;
  logic               phase_timeout;
  logic               resp_load, resp_err_d, resp_zero;
  logic [XLEN-1:0]    rd_ext;

  assign accept     = ReqValidM && (state_q == IDLE);
  assign size_word  = (ReqFunct3M == 3'b010);
  assign size_dword = (ReqFunct3M == 3'b011) && (XLEN == 64);
  assign req_bad    = !(size_word || size_dword) ||
                      (size_word  && (ReqAdrM[1:0] != 2'b00)) ||
                      (size_dword && (ReqAdrM[2:0] != 3'b000));

  assign phase_timeout = !BusAck && !BusErr && (to_cnt_q == TO_LIMIT);

  // Word reads return the low 32 bits sign-extended to the full register width.
  always_comb begin
    rd_ext = BusRData;
    if (funct3_q == 3'b010) begin
      for (int i = 32; i < XLEN; i++) rd_ext[i] = BusRData[31];
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_load  = 1'b0;
    resp_err_d = 1'b0;
    resp_zero  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValidM) begin
          if (req_bad) begin
            state_d    = RESP;
            resp_load  = 1'b1;
            resp_err_d = 1'b1;
            resp_zero  = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (BusErr || phase_timeout) begin
          state_d    = RESP;
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
          resp_zero  = 1'b1;
        end else if (BusAck) begin
          state_d = CALC;
        end
      end
      CALC: state_d = WRITE;
      WRITE: begin
        if (BusErr || phase_timeout) begin
          state_d    = RESP;
          resp_load  = 1'b1;
          resp_err_d = 1'b1;
        end else if (BusAck) begin
          state_d   = RESP;
          resp_load = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      funct7_q    <= '0;
      funct3_q    <= '0;
      rs2_q       <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q       <= ReqAdrM;
        funct7_q    <= ReqFunct7M;
        funct3_q    <= ReqFunct3M;
        rs2_q       <= ReqWDataM;
        rdata_q     <= '0;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
      if ((state_q == READ) && BusAck && !BusErr) rdata_q <= rd_ext;
      if (state_q == CALC) wdata_q <= AluResult;
      // Response registers hold after RESP so the LSU can sample them late.
      if (resp_load) begin
        rsp_rdata_q <= resp_zero ? '0 : rdata_q;
        rsp_err_q   <= resp_err_d;
      end
      if (((state_d == READ) && (state_q != READ)) ||
          ((state_d == WRITE) && (state_q != WRITE))) begin
        to_cnt_q <= '0;
      end else if (((state_q == READ) || (state_q == WRITE)) && (to_cnt_q != 8'hFF)) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
    end
  end

  assign ReqReadyM    = (state_q == IDLE);
  assign Busy         = (state_q != IDLE);
  assign RspValid     = (state_q == RESP);
  assign RspRData     = rsp_rdata_q;
  assign RspErr       = rsp_err_q;
  assign BusReq       = (state_q == READ) || (state_q == WRITE);
  assign BusWrite     = (state_q == WRITE);
  assign BusLock      = (state_q == READ) || (state_q == CALC) || (state_q == WRITE);
  assign BusAdr       = adr_q;
  assign BusSize      = funct3_q[1:0];
  assign BusWData     = wdata_q;
  assign AluReadData  = rdata_q;
  assign AluWriteData = rs2_q;
  assign AluFunct7    = funct7_q;
  assign AluFunct3    = funct3_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_amo_bus_ctrl.sv
// Bench for amo_bus_ctrl: a table of AMO transactions against a scripted bus and a
// small amoalu, plus hand-written timeout and mid-operation reset sequences.
module tb_amo_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValidM;
  logic        ReqReadyM;
  logic [55:0] ReqAdrM;
  logic [6:0]  ReqFunct7M;
  logic [2:0]  ReqFunct3M;
  logic [63:0] ReqWDataM;
  logic        RspValid;
  logic [63:0] RspRData;
  logic        RspErr;
  logic [63:0] AluReadData, AluWriteData, AluResult;
  logic [6:0]  AluFunct7;
  logic [2:0]  AluFunct3;
  logic        BusReq, BusWrite, BusLock;
  logic [55:0] BusAdr;
  logic [1:0]  BusSize;
  logic [63:0] BusWData;
  logic        BusAck, BusErr;
  logic [63:0] BusRData;
  logic        Busy;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  amo_bus_ctrl #(.XLEN(64), .PA_BITS(56), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ReqValidM(ReqValidM), .ReqReadyM(ReqReadyM), .ReqAdrM(ReqAdrM),
    .ReqFunct7M(ReqFunct7M), .ReqFunct3M(ReqFunct3M), .ReqWDataM(ReqWDataM),
    .RspValid(RspValid), .RspRData(RspRData), .RspErr(RspErr),
    .AluReadData(AluReadData), .AluWriteData(AluWriteData),
    .AluFunct7(AluFunct7), .AluFunct3(AluFunct3), .AluResult(AluResult),
    .BusReq(BusReq), .BusWrite(BusWrite), .BusLock(BusLock),
    .BusAdr(BusAdr), .BusSize(BusSize), .BusWData(BusWData),
    .BusAck(BusAck), .BusErr(BusErr), .BusRData(BusRData),
    .Busy(Busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // External amoalu stand-in: add/swap/xor/and/or, word results sign-extended.
  always_comb begin
    logic [63:0] r;
    case (AluFunct7[6:2])
      5'b00000: r = AluReadData + AluWriteData;
      5'b00001: r = AluWriteData;
      5'b00100: r = AluReadData ^ AluWriteData;
      5'b01100: r = AluReadData & AluWriteData;
      5'b01000: r = AluReadData | AluWriteData;
      default:  r = '0;
    endcase
    if (AluFunct3 == 3'b010) r = {{32{r[31]}}, r[31:0]};
    AluResult = r;
  end

  typedef struct {
    logic [55:0] adr;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] rs2;
    logic [63:0] mem;
    int          rd_lat;
    int          wr_lat;
    bit          rd_err;
    bit          wr_err;
    logic [63:0] exp_rdata;
    logic [63:0] exp_wdata;
    bit          exp_err;
    bit          exp_bus;
    bit          exp_wr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input int i);
    vec_t        v;
    int          cyc, rd_wait, wr_wait;
    bit          got, saw_req, saw_wr, lock_ok, adr_ok;
    logic [63:0] rsp_d, wd;
    logic        rsp_e;
    v = vecs[i];
    cyc = 0; rd_wait = 0; wr_wait = 0;
    got = 0; saw_req = 0; saw_wr = 0; lock_ok = 1; adr_ok = 1;
    rsp_d = '0; rsp_e = 1'b0; wd = '0;
    chk($sformatf("v%0d ready", i), 64'(ReqReadyM), 64'd1);
    ReqValidM = 1'b1; ReqAdrM = v.adr; ReqFunct7M = v.f7; ReqFunct3M = v.f3; ReqWDataM = v.rs2;
    @(negedge clk);
    ReqValidM = 1'b0;
    while (!got && cyc < 400) begin
      BusAck = 1'b0; BusErr = 1'b0;
      if (RspValid) begin
        got = 1; rsp_d = RspRData; rsp_e = RspErr;
      end else begin
        if (Busy && !BusLock) lock_ok = 0;
        if (BusReq) begin
          saw_req = 1;
          if (BusAdr !== v.adr || BusSize !== v.f3[1:0]) adr_ok = 0;
          if (BusWrite) begin
            saw_wr = 1; wd = BusWData;
            if (wr_wait == v.wr_lat) begin BusErr = v.wr_err; BusAck = !v.wr_err; end
            else wr_wait++;
          end else begin
            BusRData = v.mem;
            if (rd_wait == v.rd_lat) begin BusErr = v.rd_err; BusAck = !v.rd_err; end
            else rd_wait++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    BusAck = 1'b0; BusErr = 1'b0;
    chk($sformatf("v%0d latency", i), 64'(got ? cyc + 1 : 999), 64'(v.exp_lat));
    chk($sformatf("v%0d rsp_err", i), 64'(rsp_e), 64'(v.exp_err));
    chk($sformatf("v%0d rsp_rdata", i), rsp_d, v.exp_rdata);
    chk($sformatf("v%0d bus_used", i), 64'(saw_req), 64'(v.exp_bus));
    chk($sformatf("v%0d write_phase", i), 64'(saw_wr), 64'(v.exp_wr));
    chk($sformatf("v%0d lock_held", i), 64'(lock_ok), 64'd1);
    chk($sformatf("v%0d adr_size", i), 64'(adr_ok), 64'd1);
    if (v.exp_wr) chk($sformatf("v%0d bus_wdata", i), wd, v.exp_wdata);
    @(negedge clk);
    chk($sformatf("v%0d rsp_one_cycle", i), 64'(RspValid), 64'd0);
    chk($sformatf("v%0d rdata_hold", i), RspRData, v.exp_rdata);
    chk($sformatf("v%0d ready_after", i), 64'(ReqReadyM), 64'd1);
  endtask

  initial begin
    int  cyc;
    bit  stray;
    //           adr         f7          f3      rs2                     mem                     rdl wrl rde   wre   exp_rdata               exp_wdata               err   bus   wr    lat
    vecs[0] = '{56'h1000, 7'b0000000, 3'b011, 64'd3,                  64'd5,                  2, 0, 1'b0, 1'b0, 64'd5,                  64'd8,                  1'b0, 1'b1, 1'b1, 6};
    vecs[1] = '{56'h2004, 7'b0000100, 3'b010, 64'h1234_5678_CAFE_F00D, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 1'b1, 1'b1, 4};
    vecs[2] = '{56'h1004, 7'b0000000, 3'b011, 64'd7,                  64'd9,                  0, 0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{56'h2002, 7'b0000000, 3'b010, 64'd7,                  64'd9,                  0, 0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{56'h3000, 7'b0000000, 3'b000, 64'd7,                  64'd9,                  0, 0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{56'h3008, 7'b0000000, 3'b111, 64'd7,                  64'd9,                  0, 0, 1'b0, 1'b0, 64'd0,                  64'd0,                  1'b1, 1'b0, 1'b0, 1};
    vecs[6] = '{56'h4000, 7'b0000000, 3'b011, 64'd1,                  64'h55,                 1, 0, 1'b1, 1'b0, 64'd0,                  64'd0,                  1'b1, 1'b1, 1'b0, 3};
    vecs[7] = '{56'h5008, 7'b0010000, 3'b011, 64'h0FF0,               64'hF0F0,               0, 1, 1'b0, 1'b1, 64'hF0F0,               64'hFF00,               1'b1, 1'b1, 1'b1, 5};
    vecs[8] = '{56'h6008, 7'b0110000, 3'b010, 64'hFF,                 64'hDEAD_BEEF_7FFF_FF0F, 0, 0, 1'b0, 1'b0, 64'h0000_0000_7FFF_FF0F, 64'h0F,                 1'b0, 1'b1, 1'b1, 4};
    vecs[9] = '{56'h7FF8, 7'b0100000, 3'b011, 64'h100,                64'h8000_0000_0000_0001, 0, 3, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0101, 1'b0, 1'b1, 1'b1, 7};

    reset = 1'b0; ReqValidM = 1'b0; ReqAdrM = '0; ReqFunct7M = '0; ReqFunct3M = '0;
    ReqWDataM = '0; BusAck = 1'b0; BusErr = 1'b0; BusRData = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 64'(ReqReadyM), 64'd1);
    chk("rst rspvalid", 64'(RspValid), 64'd0);
    chk("rst busreq", 64'(BusReq), 64'd0);
    chk("rst buslock", 64'(BusLock), 64'd0);
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst rdata", RspRData, 64'd0);
    chk("rst wdata", BusWData, 64'd0);
    chk("rst adr", 64'(BusAdr), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Read phase never acknowledged: counter runs 0..255, then error response.
    ReqValidM = 1'b1; ReqAdrM = 56'h8000; ReqFunct7M = 7'b0000000; ReqFunct3M = 3'b011; ReqWDataM = 64'd1;
    @(negedge clk);
    ReqValidM = 1'b0;
    cyc = 0;
    while (!RspValid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("to latency", 64'(cyc + 1), 64'd257);
    chk("to err", 64'(RspErr), 64'd1);
    chk("to busreq", 64'(BusReq), 64'd0);
    chk("to buslock", 64'(BusLock), 64'd0);
    @(negedge clk);
    chk("to buslock after", 64'(BusLock), 64'd0);
    chk("to ready after", 64'(ReqReadyM), 64'd1);
    run_vec(0);

    // Reset asserted while the write phase is waiting for its ack.
    ReqValidM = 1'b1; ReqAdrM = 56'h9000; ReqFunct7M = 7'b0000000; ReqFunct3M = 3'b011; ReqWDataM = 64'd2;
    @(negedge clk);
    ReqValidM = 1'b0;
    cyc = 0;
    while (!(BusReq && BusWrite) && cyc < 20) begin
      BusAck = BusReq && !BusWrite;
      BusRData = 64'd1;
      @(negedge clk);
      cyc++;
    end
    BusAck = 1'b0;
    chk("rstw write reached", 64'(BusReq && BusWrite), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw ready", 64'(ReqReadyM), 64'd1);
    chk("rstw busreq", 64'(BusReq), 64'd0);
    chk("rstw buslock", 64'(BusLock), 64'd0);
    chk("rstw rspvalid", 64'(RspValid), 64'd0);
    reset = 1'b1;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (RspValid) stray = 1;
    end
    chk("rstw no response", 64'(stray), 64'd0);
    run_vec(1);
    run_vec(8);
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
